// File: rtl/pipe_ctrl_unit_pkg.sv
`default_nettype none
// ============================================================================
// pipe_ctrl_unit_pkg : opcode/funct constants, ALU encodings, control bundles
// Revision 1.0
// ============================================================================
package pipe_ctrl_unit_pkg;

  localparam int CNT_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_MUL = 6'b011000;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALUC_AND = 4'b0000;
  localparam logic [3:0] ALUC_OR  = 4'b0001;
  localparam logic [3:0] ALUC_ADD = 4'b0010;
  localparam logic [3:0] ALUC_SUB = 4'b0110;
  localparam logic [3:0] ALUC_SLT = 4'b0111;
  localparam logic [3:0] ALUC_MUL = 4'b1111;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       mem_write;
    logic       branch;
    logic       bne;
    logic       alusrc;
    logic       regdst;
    logic       is_mul;
    logic [3:0] aluc;
  } ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic mem_write;
    logic branch;
    logic bne;
  } mem_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
`default_nettype none
// ============================================================================
// ctrl_decode : combinational instruction decode (SLT via PIPE_CTRL_SLT_EN)
// Revision 1.0
// ============================================================================
module ctrl_decode
  import pipe_ctrl_unit_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        legal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    ctrl  = CTRL_NOP;
    legal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        case (funct)
          FN_ADD: ctrl.aluc = ALUC_ADD;
          FN_SUB: ctrl.aluc = ALUC_SUB;
          FN_AND: ctrl.aluc = ALUC_AND;
          FN_OR:  ctrl.aluc = ALUC_OR;
          FN_MUL: begin
            ctrl.aluc   = ALUC_MUL;
            ctrl.is_mul = 1'b1;
          end
`ifdef PIPE_CTRL_SLT_EN
          FN_SLT: ctrl.aluc = ALUC_SLT;
`endif
          default: legal = 1'b0;
        endcase
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.aluc   = ALUC_SUB;
      end
      OP_BNE: begin
        ctrl.branch = 1'b1;
        ctrl.bne    = 1'b1;
        ctrl.aluc   = ALUC_SUB;
      end
      OP_ADDI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluc     = ALUC_ADD;
      end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluc     = ALUC_ADD;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alusrc    = 1'b1;
        ctrl.aluc      = ALUC_ADD;
      end
      OP_J:    ctrl = CTRL_NOP;
      default: legal = 1'b0;
    endcase
    // An undecodable instruction must not leak partial controls into D.
    if (!legal) ctrl = CTRL_NOP;
  end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// pipe_ctrl_unit : D/E/M/W control pipeline with multiply stall, hold, flush.
// Optional macro PIPE_CTRL_SLT_EN enables SLT decode.   Revision 1.0
// ============================================================================
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int ALUC_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic              hold,
  input  logic              flush,
  output logic              busy,
  output logic              illegal,
  output logic [ALUC_W-1:0] ex_aluc,
  output logic              ex_alusrc,
  output logic              ex_regdst,
  output logic              mem_write,
  output logic              mem_branch,
  output logic              mem_bne,
  output logic              wb_regwrite,
  output logic              wb_memtoreg
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

  ctrl_t            dec_ctrl;
  logic             dec_legal;
  ctrl_t            d_ctrl, e_ctrl;
  mem_ctrl_t        m_ctrl;
  wb_ctrl_t         w_ctrl;
  logic             d_valid, e_valid, m_valid, w_valid;
  logic [CNT_W-1:0] mul_cnt;
  logic             illegal_q;
  logic             take;
  logic             capture;
  logic             kill_e;
  logic             unused_e_mul;

  ctrl_decode u_ctrl_decode (
    .instr (instr),
    .ctrl  (dec_ctrl),
    .legal (dec_legal)
  );

  assign busy         = (mul_cnt != '0);
  assign take         = instr_valid && !hold && !busy;
  assign capture      = take && dec_legal;
  assign kill_e       = flush || busy;
  assign unused_e_mul = e_ctrl.is_mul;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid   <= 1'b0;
      d_ctrl    <= CTRL_NOP;
      e_valid   <= 1'b0;
      e_ctrl    <= CTRL_NOP;
      m_valid   <= 1'b0;
      m_ctrl    <= '0;
      w_valid   <= 1'b0;
      w_ctrl    <= '0;
      mul_cnt   <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= take && !dec_legal;

      // Flush overrides hold and the multiply stall, but only for D and E.
      if (flush) begin
        d_valid <= 1'b0;
        d_ctrl  <= CTRL_NOP;
        e_valid <= 1'b0;
        e_ctrl  <= CTRL_NOP;
        mul_cnt <= '0;
      end else if (!hold && busy) begin
        mul_cnt <= mul_cnt - CNT_W'(1);
      end else if (!hold) begin
        d_valid <= capture;
        d_ctrl  <= capture ? dec_ctrl : CTRL_NOP;
        e_valid <= d_valid;
        e_ctrl  <= d_ctrl;
        if (d_valid && d_ctrl.is_mul) mul_cnt <= MUL_LOAD;
      end

      if (!hold) begin
        m_valid <= e_valid && !kill_e;
        m_ctrl  <= kill_e ? '0 : '{regwrite:  e_ctrl.regwrite,
                                   memtoreg:  e_ctrl.memtoreg,
                                   mem_write: e_ctrl.mem_write,
                                   branch:    e_ctrl.branch,
                                   bne:       e_ctrl.bne};
        w_valid <= m_valid;
        w_ctrl  <= '{regwrite: m_ctrl.regwrite, memtoreg: m_ctrl.memtoreg};
      end
    end
  end

  assign illegal     = illegal_q;
  assign ex_aluc     = e_valid ? ALUC_W'(e_ctrl.aluc) : '0;
  assign ex_alusrc   = e_valid && e_ctrl.alusrc;
  assign ex_regdst   = e_valid && e_ctrl.regdst;
  assign mem_write   = m_valid && m_ctrl.mem_write;
  assign mem_branch  = m_valid && m_ctrl.branch;
  assign mem_bne     = m_valid && m_ctrl.bne;
  assign wb_regwrite = w_valid && w_ctrl.regwrite;
  assign wb_memtoreg = w_valid && w_ctrl.memtoreg;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// tb_pipe_ctrl_unit : decode table, directed corner sequences, random vs model
// Revision 1.0
// ============================================================================
module tb_pipe_ctrl_unit;

  localparam int MUL_LAT = 3;
  localparam int ALUC_W  = 4;
`ifdef PIPE_CTRL_SLT_EN
  localparam bit SLT_EN = 1'b1;
`else
  localparam bit SLT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       instr = '0;
  logic              instr_valid = 1'b0;
  logic              hold = 1'b0;
  logic              flush = 1'b0;
  logic              busy, illegal;
  logic [ALUC_W-1:0] ex_aluc;
  logic              ex_alusrc, ex_regdst, mem_write, mem_branch, mem_bne;
  logic              wb_regwrite, wb_memtoreg;

  int checks = 0;
  int errors = 0;

  pipe_ctrl_unit #(.MUL_LAT(MUL_LAT), .ALUC_W(ALUC_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .hold(hold), .flush(flush), .busy(busy), .illegal(illegal),
    .ex_aluc(ex_aluc), .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst),
    .mem_write(mem_write), .mem_branch(mem_branch), .mem_bne(mem_bne),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Behavioural model: instruction records travelling through stage slots.
  // The multiply stall is modelled as "the mul occupies E for MUL_LAT cycles".
  typedef struct packed {
    logic v, rw, mtr, mw, br, bne, as, rd, mul;
    logic [3:0] aluc;
  } rec_t;

  rec_t sd, se, sm, sw;
  int   e_age;
  bit   m_ill;

  function automatic rec_t ref_decode(input logic [31:0] i, output bit ok);
    rec_t r;
    r = '0; r.v = 1'b1; ok = 1'b1;
    case (i[31:26])
      6'h00: begin
        r.rw = 1'b1; r.rd = 1'b1;
        case (i[5:0])
          6'h20: r.aluc = 4'h2;
          6'h22: r.aluc = 4'h6;
          6'h24: r.aluc = 4'h0;
          6'h25: r.aluc = 4'h1;
          6'h18: begin r.aluc = 4'hF; r.mul = 1'b1; end
          6'h2A: if (SLT_EN) r.aluc = 4'h7; else ok = 1'b0;
          default: ok = 1'b0;
        endcase
      end
      6'h04: begin r.br = 1'b1; r.aluc = 4'h6; end
      6'h05: begin r.br = 1'b1; r.bne = 1'b1; r.aluc = 4'h6; end
      6'h08: begin r.rw = 1'b1; r.as = 1'b1; r.aluc = 4'h2; end
      6'h23: begin r.rw = 1'b1; r.mtr = 1'b1; r.as = 1'b1; r.aluc = 4'h2; end
      6'h2B: begin r.mw = 1'b1; r.as = 1'b1; r.aluc = 4'h2; end
      6'h02: ;
      default: ok = 1'b0;
    endcase
    if (!ok) r = '0;
    return r;
  endfunction

  function automatic bit m_busy();
    return se.v && se.mul && (e_age < MUL_LAT - 1);
  endfunction

  task automatic model_reset();
    sd = '0; se = '0; sm = '0; sw = '0; e_age = 0; m_ill = 1'b0;
  endtask

  task automatic model_step();
    bit   stall, take, ok;
    rec_t dec;
    stall = m_busy();
    take  = instr_valid && !hold && !stall;
    dec   = ref_decode(instr, ok);
    m_ill = take && !ok;
    if (!hold) begin
      sw = sm;
      sm = (flush || stall) ? '0 : se;
    end
    if (flush) begin
      sd = '0; se = '0; e_age = 0;
    end else if (!hold) begin
      if (stall) e_age++;
      else begin
        se = sd; e_age = 0;
        sd = (take && ok) ? dec : '0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    logic [12:0] act, exp;
    act = {busy, illegal, ex_aluc, ex_alusrc, ex_regdst, mem_write, mem_branch,
           mem_bne, wb_regwrite, wb_memtoreg};
    exp = {m_busy(), m_ill, se.aluc, se.as, se.rd, sm.mw, sm.br, sm.bne, sw.rw, sw.mtr};
    check("model", 32'(act), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
    compare_model();
  endtask

  function automatic logic [12:0] all_outs();
    return {busy, illegal, ex_aluc, ex_alusrc, ex_regdst, mem_write, mem_branch,
            mem_bne, wb_regwrite, wb_memtoreg};
  endfunction

  typedef struct packed {
    logic [31:0] instr;
    logic        ill;
    logic [3:0]  aluc;
    logic        as, rd, mw, br, bne, rw, mtr;
  } vec_t;

  vec_t vecs[13];
  logic [31:0] pool[12];

  initial begin
    int busy_n, add_d;
    bit found;

    vecs[0]  = '{32'h00221820, 1'b0, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{32'h00000022, 1'b0, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{32'h00000024, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{32'h00000025, 1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{32'h10000000, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h14000000, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{32'h20000000, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{32'h8C220004, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{32'hAC000000, 1'b0, 4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h08000000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'hFC000000, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h0000003F, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    if (SLT_EN)
      vecs[12] = '{32'h0000002A, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    else
      vecs[12] = '{32'h0000002A, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    pool = '{32'h00000020, 32'h00000022, 32'h00000024, 32'h00000025, 32'h00000018,
             32'h00000018, 32'h0000002A, 32'h10000000, 32'h14000000, 32'h20000000,
             32'h8C000000, 32'hAC000000};

    // Reset state
    model_reset();
    tick(); tick();
    check("reset_state", 32'(all_outs()), 32'h0);
    rst_n = 1'b1;
    tick();

    // Decode table with per-stage latency
    foreach (vecs[k]) begin
      instr = vecs[k].instr; instr_valid = 1'b1;
      tick();
      check($sformatf("illegal[%0d]", k), 32'(illegal), 32'(vecs[k].ill));
      instr_valid = 1'b0; instr = $urandom;
      tick();
      check($sformatf("ex[%0d]", k), 32'({ex_aluc, ex_alusrc, ex_regdst}),
            32'({vecs[k].aluc, vecs[k].as, vecs[k].rd}));
      check($sformatf("illegal_end[%0d]", k), 32'(illegal), 32'h0);
      tick();
      check($sformatf("mem[%0d]", k), 32'({mem_write, mem_branch, mem_bne}),
            32'({vecs[k].mw, vecs[k].br, vecs[k].bne}));
      tick();
      check($sformatf("wb[%0d]", k), 32'({wb_regwrite, wb_memtoreg}),
            32'({vecs[k].rw, vecs[k].mtr}));
    end
    tick();

    // MUL followed by ADD: busy window and ADD arrival in E
    instr = 32'h00000018; instr_valid = 1'b1;
    tick();
    instr = 32'h00000020;
    tick();
    check("mul_in_e", 32'(ex_aluc), 32'hF);
    instr_valid = 1'b0;
    busy_n = int'(busy); add_d = 0; found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      busy_n += int'(busy);
      if (!found && ex_aluc == 4'h2) begin found = 1'b1; add_d = k; end
    end
    check("mul_busy_cycles", 32'(busy_n), 32'd2);
    check("add_to_e_delay", 32'(add_d), 32'd3);

    // BNE in E with flush and hold together
    instr = 32'hAC000000; instr_valid = 1'b1; tick();
    instr = 32'h14000000; tick();
    instr = 32'h00000020; tick();
    check("pre_flush_m_sw", 32'({mem_write, mem_bne}), 32'b10);
    instr_valid = 1'b0; flush = 1'b1; hold = 1'b1;
    tick();
    check("flush_e_bubble", 32'({ex_aluc, ex_alusrc, ex_regdst}), 32'h0);
    check("flush_hold_m", 32'({mem_write, mem_branch, mem_bne}), 32'b100);
    check("flush_hold_w", 32'({wb_regwrite, wb_memtoreg}), 32'h0);
    flush = 1'b0; hold = 1'b0;
    tick();
    check("flush_d_bubble", 32'({ex_aluc, ex_alusrc, ex_regdst}), 32'h0);
    check("flush_no_bne_m", 32'({mem_write, mem_branch, mem_bne}), 32'h0);
    tick(); tick();

    // Illegal opcode coinciding with flush
    instr = 32'hFC000000; instr_valid = 1'b1; flush = 1'b1;
    tick();
    check("illegal_with_flush", 32'(illegal), 32'h1);
    instr_valid = 1'b0; flush = 1'b0;
    tick();
    check("illegal_one_cycle", 32'(illegal), 32'h0);
    tick(); tick(); tick();

    // Reset in the second cycle of a multiply stall
    instr = 32'h00000018; instr_valid = 1'b1; tick();
    instr_valid = 1'b0; tick(); tick();
    check("busy_before_reset", 32'(busy), 32'h1);
    rst_n = 1'b0; model_reset();
    #1;
    check("reset_async", 32'(all_outs()), 32'h0);
    tick();
    rst_n = 1'b1;
    instr = 32'h8C220004; instr_valid = 1'b1;
    tick();
    check("post_reset_busy", 32'(busy), 32'h0);
    instr_valid = 1'b0;
    tick();
    check("post_reset_lw_e", 32'({ex_aluc, ex_alusrc}), 32'b00101);
    tick(); tick();
    check("post_reset_lw_w", 32'({wb_regwrite, wb_memtoreg}), 32'b11);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int idx;
      idx = $urandom_range(0, 12);
      if (idx == 12) instr = $urandom;
      else instr = pool[idx] | ($urandom & 32'h03FFFFC0);
      instr_valid = ($urandom_range(0, 9) < 7);
      hold        = ($urandom_range(0, 9) == 0);
      flush       = ($urandom_range(0, 11) == 0);
      tick();
    end
    hold = 1'b0; flush = 1'b0; instr_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameter MUL_LAT, default 3, multiply latency in cycles, legal range 1..15.
REQ-002 Parameter ALUC_W, default 4, ALU control field width; SHALL be at least 4.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 instr  in  32  fetched instruction: opcode [31:26], funct [5:0].
REQ-006 instr_valid  in  1  instr is meaningful this cycle.
REQ-007 hold  in  1  external freeze of all stages.
REQ-008 flush  in  1  branch-resolve kill of the D and E stages.
REQ-009 busy  out  1  multiply in progress; fetch SHALL not advance.
REQ-010 illegal  out  1  one-cycle pulse on an undecodable opcode or funct.
REQ-011 ex_aluc  out  ALUC_W  E-stage ALU control.
REQ-012 ex_alusrc, ex_regdst  out  1 each  E-stage operand and destination selects.
REQ-013 mem_write, mem_branch, mem_bne  out  1 each  M-stage controls.
REQ-014 wb_regwrite, wb_memtoreg  out  1 each  W-stage controls.

Function
REQ-015 Decode map: R-type 000000 sets regwrite and regdst; BEQ 000100 sets branch with ALU subtract; BNE 000101 sets branch, bne, and ALU subtract.
REQ-016 Decode map, continued: ADDI 001000 sets regwrite, alusrc, ALU add; LW 100011 sets regwrite, memtoreg, alusrc, ALU add; SW 101011 sets mem_write, alusrc, ALU add; J 000010 sets all controls 0.
REQ-017 R-type funct map to aluc: 100000 add 0010; 100010 sub 0110; 100100 and 0000; 100101 or 0001; 011000 mul 1111.
REQ-018 aluc SHALL be a pure function of the current instruction, with no dependency on prior-cycle state.
REQ-019 Stage pipeline: D, E, M, W registers, each with a valid bit; the control bundle advances one stage per cycle.
REQ-020 Output latency: controls from instr sampled at edge N appear at E after edge N+1, M after edge N+2, and W after edge N+3.
REQ-021 Any stage with valid=0 SHALL drive all of its outputs at 0.
REQ-022 D SHALL capture instr only when instr_valid=1, hold=0, and busy=0; otherwise D receives a bubble, except that it holds its contents under hold or busy.
REQ-023 Undecodable opcode or funct: D receives a bubble and illegal pulses for exactly one cycle.
REQ-024 Multiply: when mul enters E, the counter SHALL load MUL_LAT-1; busy=1 while the counter is nonzero.
REQ-025 While busy=1, D and E hold, M receives a bubble each cycle, and the counter decrements.
REQ-026 MUL_LAT=1: busy SHALL never assert.
REQ-027 hold=1 freezes every stage and the counter; it takes precedence over busy decrement.
REQ-028 flush=1 loads bubbles into D and E and clears the counter; it takes precedence over hold and busy for D and E only.
REQ-029 Simultaneous flush and illegal: illegal SHALL still pulse.

Reset
REQ-030 rst_n low SHALL immediately clear all valid bits, the counter, busy, illegal, and every output to 0.
REQ-031 Reset asserted mid-multiply SHALL abandon the operation; no residual busy may follow reset release.

Configuration
REQ-032 Macro PIPE_CTRL_SLT_EN defined: funct 101010 decodes as set-less-than, with aluc 0111 and regwrite=1.
REQ-033 Macro PIPE_CTRL_SLT_EN undefined: funct 101010 is illegal.

Structure
REQ-034 A shared package SHALL hold opcode and funct constants, the aluc encodings, and a control-bundle struct typedef.
REQ-035 Combinational decode SHALL be a sub-module, ctrl_decode, instantiated once; stage registers and the counter remain in pipe_ctrl_unit.

Verification
REQ-036 LW 0x8C220004 valid at edge 1: ex_alusrc=1 and ex_aluc=0010 after edge 2; wb_memtoreg=1 and wb_regwrite=1 after edge 4.
REQ-037 MUL funct 011000 with MUL_LAT=3: busy=1 for exactly 2 cycles; a following ADD reaches E 3 cycles after MUL.
REQ-038 BNE in E with flush=1 and hold=1 asserted together: E and D become bubbles; M, W, and mem_bne are unaffected by that cycle.
REQ-039 Opcode 111111: illegal=1 for one cycle; no regwrite ever appears at W.
REQ-040 rst_n driven low during cycle 2 of a busy window: busy and all outputs 0 immediately; after release, the next instruction flows with normal latency.
REQ-041 funct 101010 with the macro defined: ex_aluc=0111; without the macro: illegal=1.
